// File: rtl/leg4_pkg.sv
// Shared constants for the leg4 program loader: frame markers, reply bytes,
// FSM encodings and the 16x oversample divisor helper.
package leg4_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] ACK      = 8'h4B;
   localparam logic [7:0] NAK      = 8'h45;

   typedef enum logic [1:0] {
      L_IDLE = 2'd0,
      L_DATA = 2'd1,
      L_CSUM = 2'd2
   } load_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

   // round(clk_hz / (baud * 16)), never below 1
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      int unsigned d;
      d = (clk_hz + baud * 8) / (baud * 16);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/leg4_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and 16x oversampling.
// Emits a 1-cycle byte_valid pulse on a good stop bit, frame_err on a low one.
module leg4_uart_rx
   import leg4_pkg::*;
#(
   parameter int unsigned DIV = 78
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic             rx_s1;
   logic             rx_s2;
   logic             rx_d;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   rx_state_t        state;

   assign tick    = (div_cnt == DIV_LAST);
   assign rx_byte = shift;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // Divider is held at zero while idle so tick phase lines up with the start edge
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         div_cnt <= '0;
      end else if (state == R_IDLE || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= R_IDLE;
         tick_cnt   <= 4'd0;
         bit_cnt    <= 3'd0;
         shift      <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            R_IDLE: begin
               if (rx_d && !rx_s2) begin
                  state    <= R_START;
                  tick_cnt <= 4'd0;
               end
            end
            R_START: begin
               if (tick) begin
                  if (tick_cnt == 4'd7) begin
                     // A line already back high mid-start is a glitch, not a byte
                     if (rx_s2) begin
                        state <= R_IDLE;
                     end else begin
                        state    <= R_DATA;
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            R_DATA: begin
               if (tick) begin
                  if (tick_cnt == 4'd15) begin
                     tick_cnt <= 4'd0;
                     shift    <= {rx_s2, shift[7:1]};
                     if (bit_cnt == 3'd7) begin
                        state <= R_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            R_STOP: begin
               if (tick) begin
                  if (tick_cnt == 4'd15) begin
                     state <= R_IDLE;
                     if (rx_s2) begin
                        byte_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/leg4_prog_loader.sv
// UART program loader and writable 16x8 program memory for the leg4 CPU.
// Optional byte echo and K/E reply on tx when LEG4_LOADER_ECHO_EN is defined.
module leg4_prog_loader
   import leg4_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 12000000,
   parameter int unsigned BAUD        = 9600,
   parameter int unsigned TIMEOUT_CYC = 12000000,
   parameter logic [7:0]  HDR_BYTE    = leg4_pkg::HDR_BYTE
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   input  logic [3:0] address,
   output logic [7:0] rom_out,
   output logic       cpu_hold,
   output logic       done,
   output logic       err
`ifdef LEG4_LOADER_ECHO_EN
   ,
   output logic       tx
`endif
);

   localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
   localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic              byte_valid;
   logic [7:0]        rx_byte;
   logic              frame_err;
   logic [7:0]        mem [16];
   logic [3:0]        cnt;
   logic [7:0]        sum;
   logic [TMO_W-1:0]  tmo;
   load_state_t       state;

   leg4_uart_rx #(.DIV(DIV)) u_rx (
      .clk        (clk),
      .nrst       (nrst),
      .rx         (rx),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   // Registered write: a same-cycle read of the written slot sees the old byte
   assign rom_out = mem[address];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= L_IDLE;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cnt      <= 4'd0;
         sum      <= 8'h00;
         tmo      <= '0;
         for (int i = 0; i < 16; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         case (state)
            L_IDLE: begin
               if (byte_valid && rx_byte == HDR_BYTE) begin
                  state    <= L_DATA;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cnt      <= 4'd0;
                  sum      <= 8'h00;
                  tmo      <= '0;
               end
            end
            L_DATA: begin
               if (byte_valid) begin
                  mem[cnt] <= rx_byte;
                  sum      <= sum + rx_byte;
                  cnt      <= cnt + 4'd1;
                  tmo      <= '0;
                  if (cnt == 4'd15) begin
                     state <= L_CSUM;
                  end
               end else if (frame_err || tmo == TMO_LAST) begin
                  state    <= L_IDLE;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  tmo <= tmo + TMO_W'(1);
               end
            end
            L_CSUM: begin
               if (byte_valid) begin
                  state    <= L_IDLE;
                  cpu_hold <= 1'b0;
                  if (rx_byte == sum) begin
                     done <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (frame_err || tmo == TMO_LAST) begin
                  state    <= L_IDLE;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  tmo <= tmo + TMO_W'(1);
               end
            end
            default: state <= L_IDLE;
         endcase
      end
   end

`ifdef LEG4_LOADER_ECHO_EN
   localparam int unsigned BIT_CYC = DIV * 16;
   localparam int BIT_W = $clog2(BIT_CYC);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYC - 1);

   logic             tx_busy;
   logic [8:0]       tx_sh;
   logic [3:0]       tx_bit;
   logic [BIT_W-1:0] tx_cnt;
   logic             hold_valid;
   logic [7:0]       hold_byte;
   logic             resp_valid;
   logic [7:0]       resp_byte;
   logic             csum_event;

   assign csum_event = (state == L_CSUM) && byte_valid;

   // Echoes take priority; the K/E reply waits until they have drained
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
         tx_sh      <= 9'h1FF;
         tx_bit     <= 4'd0;
         tx_cnt     <= '0;
         hold_valid <= 1'b0;
         hold_byte  <= 8'h00;
         resp_valid <= 1'b0;
         resp_byte  <= 8'h00;
      end else begin
         if (csum_event) begin
            resp_valid <= 1'b1;
            resp_byte  <= (rx_byte == sum) ? ACK : NAK;
         end
         if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt <= '0;
               if (tx_bit == 4'd9) begin
                  tx_busy <= 1'b0;
                  tx      <= 1'b1;
               end else begin
                  tx_bit <= tx_bit + 4'd1;
                  tx     <= tx_sh[0];
                  tx_sh  <= {1'b1, tx_sh[8:1]};
               end
            end else begin
               tx_cnt <= tx_cnt + BIT_W'(1);
            end
            if (byte_valid && !hold_valid) begin
               hold_valid <= 1'b1;
               hold_byte  <= rx_byte;
            end
         end else if (hold_valid) begin
            tx_busy <= 1'b1;
            tx      <= 1'b0;
            tx_sh   <= {1'b1, hold_byte};
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            if (byte_valid) begin
               hold_byte <= rx_byte;
            end else begin
               hold_valid <= 1'b0;
            end
         end else if (byte_valid) begin
            tx_busy <= 1'b1;
            tx      <= 1'b0;
            tx_sh   <= {1'b1, rx_byte};
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
         end else if (resp_valid) begin
            tx_busy    <= 1'b1;
            tx         <= 1'b0;
            tx_sh      <= {1'b1, resp_byte};
            tx_bit     <= 4'd0;
            tx_cnt     <= '0;
            resp_valid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_leg4_prog_loader.sv
// Bench for leg4_prog_loader: frame table plus hand-written abort, idle and
// reset sequences; echo stream is checked when LEG4_LOADER_ECHO_EN is defined.
module tb_leg4_prog_loader;

   localparam int BIT = 16;   // clocks per bit with BAUD = CLK_HZ / 16

   logic       clk;
   logic       nrst;
   logic       rx;
   logic [3:0] address;
   logic [7:0] rom_out;
   logic       cpu_hold;
   logic       done;
   logic       err;
`ifdef LEG4_LOADER_ECHO_EN
   logic       tx;
   logic [7:0] got_q[$];
   logic [7:0] echo_exp_q[$];
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [1:0] st_q[$];
   logic [7:0] model_mem[16];

   typedef struct {
      logic [7:0] base;
      logic [7:0] delta;
      logic       exp_done;
      logic       exp_err;
   } fvec_t;
   fvec_t ftab[5];

   leg4_prog_loader #(
      .CLK_HZ      (12000000),
      .BAUD        (750000),
      .TIMEOUT_CYC (600),
      .HDR_BYTE    (8'hA5)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .rx       (rx),
      .address  (address),
      .rom_out  (rom_out),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
`ifdef LEG4_LOADER_ECHO_EN
      ,
      .tx       (tx)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input logic stop_low);
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = ~stop_low;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic wait_hold_low(input int budget);
      for (int c = 0; c < budget && cpu_hold; c++) @(negedge clk);
      chk("hold_release", cpu_hold, 1'b0);
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < 16; i++) exp_q.push_back(model_mem[i]);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         address = 4'(i);
         #1;
         if (exp_q.size() == 0) begin
            chk({name, "_underflow"}, 32'd0, 32'd1);
         end else begin
            chk(name, rom_out, exp_q.pop_front());
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] base, input logic [7:0] delta,
                            input logic exp_done, input logic exp_err);
      logic [7:0] s;
      logic [7:0] b;
      logic [1:0] st;
      s = 8'h00;
      st_q.push_back({exp_done, exp_err});
      send_byte(8'hA5, 1'b0);
      chk("hold_after_hdr", cpu_hold, 1'b1);
      for (int i = 0; i < 16; i++) begin
         b = base + 8'(i);
         send_byte(b, 1'b0);
         s = s + b;
         model_mem[i] = b;
      end
      chk("hold_before_csum", cpu_hold, 1'b1);
      send_byte(s + delta, 1'b0);
      wait_hold_low(200);
      st = st_q.pop_front();
      chk("frame_done", done, st[1]);
      chk("frame_err", err, st[0]);
      check_mem("frame_mem");
   endtask

`ifdef LEG4_LOADER_ECHO_EN
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (nrst && tx === 1'b0) begin
            repeat (8) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            got_q.push_back(b);
         end
      end
   end
`endif

   initial begin
      ftab[0] = '{8'h00, 8'h00, 1'b1, 1'b0};
      ftab[1] = '{8'h00, 8'h01, 1'b0, 1'b1};
      ftab[2] = '{8'hA0, 8'h00, 1'b1, 1'b0};
      ftab[3] = '{8'h55, 8'hFF, 1'b0, 1'b1};
      ftab[4] = '{8'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b0};

      nrst = 1'b0;
      rx = 1'b1;
      address = 4'd0;
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      repeat (4) @(negedge clk);
      chk("rst_hold", cpu_hold, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      check_mem("rst_mem");
      nrst = 1'b1;
      repeat (4) @(negedge clk);

`ifdef LEG4_LOADER_ECHO_EN
      got_q.delete();
      echo_exp_q.push_back(8'hA5);
      for (int i = 0; i < 16; i++) echo_exp_q.push_back(8'(i));
      echo_exp_q.push_back(8'h78);
      echo_exp_q.push_back(8'h4B);
      run_frame(8'h00, 8'h00, 1'b1, 1'b0);
      for (int c = 0; c < 2000 && got_q.size() < 19; c++) @(negedge clk);
      chk("echo_count", got_q.size(), 19);
      while (echo_exp_q.size() > 0 && got_q.size() > 0) begin
         chk("echo_byte", got_q.pop_front(), echo_exp_q.pop_front());
      end
`endif

      for (int t = 0; t < 5; t++) begin
         run_frame(ftab[t].base, ftab[t].delta, ftab[t].exp_done, ftab[t].exp_err);
      end

      // bytes other than the header are ignored while idle
      send_byte(8'h3C, 1'b0);
      send_byte(8'h12, 1'b0);
      chk("idle_hold", cpu_hold, 1'b0);
      chk("idle_done", done, 1'b1);
      chk("idle_err", err, 1'b0);

      // framing error in idle leaves flags alone
      send_byte(8'h77, 1'b1);
      chk("idle_ferr_err", err, 1'b0);
      chk("idle_ferr_done", done, 1'b1);

      // inter-byte timeout
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send_byte(8'hE0 + 8'(i), 1'b0);
         model_mem[i] = 8'hE0 + 8'(i);
      end
      chk("tmo_hold_start", cpu_hold, 1'b1);
      repeat (450) @(negedge clk);
      chk("tmo_not_yet", cpu_hold, 1'b1);
      repeat (300) @(negedge clk);
      chk("tmo_err", err, 1'b1);
      chk("tmo_hold", cpu_hold, 1'b0);
      chk("tmo_done", done, 1'b0);
      check_mem("tmo_mem");

      // framing error mid-frame, then a good frame recovers
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'hC1 + 8'(i), 1'b0);
         model_mem[i] = 8'hC1 + 8'(i);
      end
      send_byte(8'hC4, 1'b1);
      chk("ferr_err", err, 1'b1);
      chk("ferr_hold", cpu_hold, 1'b0);
      chk("ferr_done", done, 1'b0);
      check_mem("ferr_mem");
      run_frame(8'h30, 8'h00, 1'b1, 1'b0);

      // reset mid-frame clears everything
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 1'b0);
      chk("mid_hold", cpu_hold, 1'b1);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("mrst_hold", cpu_hold, 1'b0);
      chk("mrst_done", done, 1'b0);
      chk("mrst_err", err, 1'b0);
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      check_mem("mrst_mem");
      nrst = 1'b1;
      repeat (4) @(negedge clk);
      run_frame(8'h07, 8'h00, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
